// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
// Optional build macro: CLKDIV_SYNC_EN.
package clk_div_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/clk_div_gen_if.sv
// Per-channel divider bundle: controls in, divided outputs back.
// Optional build macro: CLKDIV_SYNC_EN adds the sync strobe.
interface clk_div_gen_if #(
  parameter int CNT_W = clk_div_pkg::DEF_CNT_W
);

  logic             en;
  logic [CNT_W-1:0] div;
`ifdef CLKDIV_SYNC_EN
  logic             sync;
`endif
  logic             clk;
  logic             tick;
  logic             active;

  modport master (
`ifdef CLKDIV_SYNC_EN
    output sync,
`endif
    output en,
    output div,
    input  clk,
    input  tick,
    input  active
  );

  modport slave (
`ifdef CLKDIV_SYNC_EN
    input  sync,
`endif
    input  en,
    input  div,
    output clk,
    output tick,
    output active
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, latched divisor, registered outputs.
// Optional build macro: CLKDIV_SYNC_EN.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input logic          clk_i,
  input logic          rst_n,
  clk_div_gen_if.slave bus
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nl_q, nl_d;
  logic [CNT_W-1:0] half_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             run_d;
  logic             wrap;
  logic             reload;
  logic             sync_hit;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = bus.sync;
`else
  assign sync_hit = 1'b0;
`endif

  assign wrap   = (state_q == CH_RUN) &&
                  (cnt_q == nl_q - 1'b1);
  assign reload = sync_hit || wrap ||
                  (state_q == CH_IDLE);

  // Nl only changes at a period boundary, so outputs never glitch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nl_d    = nl_q;
    unique case (1'b1)
      !bus.en: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
        nl_d    = '0;
      end
      bus.en && reload: begin
        nl_d    = bus.div;
        cnt_d   = '0;
        state_d = (bus.div != '0) ? CH_RUN
                                  : CH_IDLE;
      end
      bus.en && !reload: begin
        cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign run_d  = (state_d == CH_RUN);
  assign half_d = (nl_d >> 1) +
                  {{(CNT_W-1){1'b0}}, nl_d[0]};
  assign tick_d = run_d && (cnt_d == '0);
  assign clk_d  = run_d && (cnt_d < half_d);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      nl_q    <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nl_q    <= nl_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.clk    = clk_q;
  assign bus.tick   = tick_q;
  assign bus.active = (state_q == CH_RUN);

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with tick outputs.
// Optional build macro: CLKDIV_SYNC_EN adds sync_i phase alignment.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk_50mhz,
  input  logic                    rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic                    sync_i,
`endif
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       active_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_gen_if #(.CNT_W(CNT_W)) ch_if ();

    assign ch_if.en  = en_i[i];
    assign ch_if.div = div_i[i*CNT_W +: CNT_W];
`ifdef CLKDIV_SYNC_EN
    assign ch_if.sync = sync_i;
`endif
    assign clk_o[i]    = ch_if.clk;
    assign tick_o[i]   = ch_if.tick;
    assign active_o[i] = ch_if.active;

    clk_div_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i(clk_50mhz),
      .rst_n(rst_n),
      .bus  (ch_if.slave)
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen; expected waveforms come from
// the divide-by-N definition (tick at phase 0, clk high for ceil(N/2)).
`timescale 1ns/1ps
module tb_clk_div_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] act;
  } exp_t;

  logic                    clk_50mhz = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH-1:0]       en_v = '0;
  logic [NUM_CH*CNT_W-1:0] div_v = '0;
  logic [NUM_CH-1:0]       clk_o, tick_o, active_o;
`ifdef CLKDIV_SYNC_EN
  logic                    sync_i = 1'b0;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #10 clk_50mhz = ~clk_50mhz;

  clk_div_gen_if #(.CNT_W(CNT_W)) ch0_if ();
  assign ch0_if.en  = en_v[0];
  assign ch0_if.div = div_v[CNT_W-1:0];
`ifdef CLKDIV_SYNC_EN
  assign ch0_if.sync = sync_i;
`endif
  assign ch0_if.clk    = clk_o[0];
  assign ch0_if.tick   = tick_o[0];
  assign ch0_if.active = active_o[0];

  clk_div_gen #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .rst_n    (rst_n),
`ifdef CLKDIV_SYNC_EN
    .sync_i   (sync_i),
`endif
    .en_i     (en_v),
    .div_i    (div_v),
    .clk_o    (clk_o),
    .tick_o   (tick_o),
    .active_o (active_o)
  );

  function automatic exp_t model(input int ph[NUM_CH],
                                 input int per[NUM_CH]);
    exp_t e;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (per[c] > 0) begin
        int p;
        p = ph[c] % per[c];
        e.tick[c] = (p == 0);
        e.clk[c]  = (p < (per[c] + 1) / 2);
        e.act[c]  = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic set_div(input int c, input int v);
    div_v[c*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic test_reset();
    en_v = '0; div_v = '0; rst_n = 1'b0;
    #3;
    checks++;
    if ({clk_o, tick_o, active_o} !== '0) begin
      errors++;
      $display("FAIL reset_async got %b required 0",
               {clk_o, tick_o, active_o});
    end
    en_v[0] = 1'b1; set_div(0, 4);
    @(posedge clk_50mhz); #1;
    checks++;
    if (ch0_if.tick !== 1'b0 || ch0_if.clk !== 1'b0 ||
        ch0_if.active !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got clk=%b tick=%b act=%b required 0",
               ch0_if.clk, ch0_if.tick, ch0_if.active);
    end
    en_v = '0;
    @(negedge clk_50mhz);
    rst_n = 1'b1;
  endtask

  task automatic test_legacy();
    int ph[NUM_CH] = '{default: 0};
    int per[NUM_CH] = '{default: 0};
    exp_t e;
    for (int k = 0; k <= 12; k++) begin
      if (k < 12) begin
        en_v[0] = 1'b1; set_div(0, 4); ph[0] = k; per[0] = 4;
      end else begin
        en_v[0] = 1'b0; per[0] = 0;
      end
      exp_q.push_back(model(ph, per));
      @(posedge clk_50mhz); #1;
      e = exp_q.pop_front();
      checks++;
      if ({clk_o, tick_o, active_o} !== e) begin
        errors++;
        $display("FAIL legacy k=%0d got %b required %b (en=%b div=%0d)",
                 k, {clk_o, tick_o, active_o}, e,
                 ch0_if.en, ch0_if.div);
      end
    end
  endtask

  task automatic test_odd();
    int ph[NUM_CH] = '{default: 0};
    int per[NUM_CH] = '{default: 0};
    exp_t e;
    for (int k = 0; k <= 15; k++) begin
      if (k < 10) begin
        en_v[0] = 1'b1; set_div(0, 5); ph[0] = k; per[0] = 5;
      end else if (k == 10 || k == 15) begin
        en_v[0] = 1'b0; per[0] = 0;
      end else begin
        en_v[0] = 1'b1; set_div(0, 1); ph[0] = k - 11; per[0] = 1;
      end
      exp_q.push_back(model(ph, per));
      @(posedge clk_50mhz); #1;
      e = exp_q.pop_front();
      checks++;
      if ({clk_o, tick_o, active_o} !== e) begin
        errors++;
        $display("FAIL odd_div k=%0d got %b required %b",
                 k, {clk_o, tick_o, active_o}, e);
      end
    end
  endtask

  task automatic test_mid_change();
    int ph[NUM_CH] = '{default: 0};
    int per[NUM_CH] = '{default: 0};
    exp_t e;
    for (int k = 0; k <= 17; k++) begin
      en_v[0] = (k < 17);
      set_div(0, (k < 3) ? 8 : 3);
      if (k == 17)    per[0] = 0;
      else if (k < 8) begin ph[0] = k;     per[0] = 8; end
      else            begin ph[0] = k - 8; per[0] = 3; end
      exp_q.push_back(model(ph, per));
      @(posedge clk_50mhz); #1;
      e = exp_q.pop_front();
      checks++;
      if ({clk_o, tick_o, active_o} !== e) begin
        errors++;
        $display("FAIL mid_change k=%0d got %b required %b",
                 k, {clk_o, tick_o, active_o}, e);
      end
    end
  endtask

  task automatic test_disable_zero();
    int ph[NUM_CH] = '{default: 0};
    int per[NUM_CH] = '{default: 0};
    exp_t e;
    for (int k = 0; k <= 10; k++) begin
      if (k <= 5) begin
        en_v[0] = 1'b1; set_div(0, 7); ph[0] = k; per[0] = 7;
      end else if (k == 6 || k == 10) begin
        en_v[0] = 1'b0; per[0] = 0;
      end else begin
        en_v[0] = 1'b1; set_div(0, 0); per[0] = 0;
      end
      exp_q.push_back(model(ph, per));
      @(posedge clk_50mhz); #1;
      e = exp_q.pop_front();
      checks++;
      if ({clk_o, tick_o, active_o} !== e) begin
        errors++;
        $display("FAIL disable_zero k=%0d got %b required %b",
                 k, {clk_o, tick_o, active_o}, e);
      end
    end
  endtask

  task automatic test_max_div();
    int ph[NUM_CH] = '{default: 0};
    int per[NUM_CH] = '{default: 0};
    exp_t e;
    for (int k = 0; k <= 32; k++) begin
      en_v[0] = (k < 32);
      set_div(0, (1 << CNT_W) - 1);
      ph[0] = k;
      per[0] = (k < 32) ? (1 << CNT_W) - 1 : 0;
      exp_q.push_back(model(ph, per));
      @(posedge clk_50mhz); #1;
      e = exp_q.pop_front();
      checks++;
      if ({clk_o, tick_o, active_o} !== e) begin
        errors++;
        $display("FAIL max_div k=%0d got %b required %b",
                 k, {clk_o, tick_o, active_o}, e);
      end
    end
  endtask

  task automatic test_independent();
    int ph[NUM_CH] = '{default: 0};
    int per[NUM_CH] = '{default: 0};
    exp_t e;
    for (int k = 0; k <= 19; k++) begin
      set_div(0, 3); set_div(1, 5); set_div(2, 2); set_div(3, 7);
      if (k < 19) begin
        en_v[2:0] = 3'b111;
        en_v[3] = (k >= 4);
        ph[0] = k; per[0] = 3;
        ph[1] = k; per[1] = 5;
        ph[2] = k; per[2] = 2;
        ph[3] = k - 4; per[3] = (k >= 4) ? 7 : 0;
      end else begin
        en_v = '0; per = '{default: 0};
      end
      exp_q.push_back(model(ph, per));
      @(posedge clk_50mhz); #1;
      e = exp_q.pop_front();
      checks++;
      if ({clk_o, tick_o, active_o} !== e) begin
        errors++;
        $display("FAIL independent k=%0d got %b required %b",
                 k, {clk_o, tick_o, active_o}, e);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int ph[NUM_CH] = '{default: 0};
    int per[NUM_CH] = '{default: 0};
    exp_t e;
    for (int k = 0; k <= 1; k++) begin
      en_v[0] = 1'b1; set_div(0, 6); ph[0] = k; per[0] = 6;
      exp_q.push_back(model(ph, per));
      @(posedge clk_50mhz); #1;
      e = exp_q.pop_front();
      checks++;
      if ({clk_o, tick_o, active_o} !== e) begin
        errors++;
        $display("FAIL rst_pre k=%0d got %b required %b",
                 k, {clk_o, tick_o, active_o}, e);
      end
    end
    #4 rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_o, tick_o, active_o} !== '0) begin
      errors++;
      $display("FAIL rst_midrun got %b required 0",
               {clk_o, tick_o, active_o});
    end
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      en_v[0] = (k < 12); set_div(0, 6);
      ph[0] = k; per[0] = (k < 12) ? 6 : 0;
      exp_q.push_back(model(ph, per));
      @(posedge clk_50mhz); #1;
      e = exp_q.pop_front();
      checks++;
      if ({clk_o, tick_o, active_o} !== e) begin
        errors++;
        $display("FAIL rst_post k=%0d got %b required %b",
                 k, {clk_o, tick_o, active_o}, e);
      end
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    int ph[NUM_CH] = '{default: 0};
    int per[NUM_CH] = '{default: 0};
    exp_t e;
    for (int k = 0; k <= 33; k++) begin
      set_div(0, 4); set_div(1, 6);
      sync_i = (k == 8);
      if (k == 33) begin
        en_v = '0; per = '{default: 0};
      end else begin
        en_v[0] = 1'b1;
        en_v[1] = (k >= 1);
        per[0] = 4;
        per[1] = (k >= 1) ? 6 : 0;
        ph[0] = (k < 8) ? k : k - 8;
        ph[1] = (k < 8) ? k - 1 : k - 8;
      end
      exp_q.push_back(model(ph, per));
      @(posedge clk_50mhz); #1;
      e = exp_q.pop_front();
      checks++;
      if ({clk_o, tick_o, active_o} !== e) begin
        errors++;
        $display("FAIL sync k=%0d got %b required %b",
                 k, {clk_o, tick_o, active_o}, e);
      end
    end
    sync_i = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_legacy();
    test_odd();
    test_mid_change();
    test_disable_zero();
    test_max_div();
    test_independent();
    test_reset_midrun();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 16, divisor/counter width in bits (2..32).
REQ-003 clk_50mhz  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en_i  input  NUM_CH  per-channel enable, level-sensitive.
REQ-006 div_i  input  NUM_CH*CNT_W  per-channel divisor N; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-007 clk_o  output  NUM_CH  per-channel divided clock, registered.
REQ-008 tick_o  output  NUM_CH  per-channel one-cycle clock-enable pulse, registered.
REQ-009 active_o  output  NUM_CH  high while the channel runs with a nonzero latched divisor.

Function
REQ-010 Each channel SHALL hold a CNT_W-bit counter cnt and a latched divisor Nl; cnt counts 0..Nl-1, then wraps to 0.
REQ-011 tick_o[i] SHALL be high for exactly one cycle per Nl cycles, on the cycle cnt==0; period exactly Nl clocks.
REQ-012 clk_o[i] SHALL be high while cnt < ceil(Nl/2), low otherwise; its rising edge coincides with tick_o[i].
REQ-013 Nl SHALL be reloaded from div_i only on wrap (cnt==Nl-1), on enable rising, or on sync (REQ-021); mid-period div_i changes SHALL NOT alter the current period (glitch-free).
REQ-014 Channel states: IDLE (outputs low, cnt=0) and RUN; IDLE->RUN when en_i high and div_i nonzero; RUN->IDLE when en_i low, or a reload latches Nl=0.
REQ-015 First tick_o/clk_o rising edge SHALL occur on the first clock edge after en_i is sampled high with nonzero div_i (latency 1 cycle).
REQ-016 Nl==1: tick_o and clk_o SHALL stay high continuously while RUN.
REQ-017 Nl==2^CNT_W-1 (maximum): counter SHALL not overflow; period exactly 2^CNT_W-1.
REQ-018 en_i falling SHALL force outputs low and cnt to 0 on the next edge, regardless of phase.
REQ-019 Channels SHALL be fully independent; no cross-channel interaction except REQ-021.

Reset
REQ-020 rst_n low SHALL immediately clear cnt, Nl, clk_o, tick_o, active_o to 0 in all channels; after release, channels start per REQ-015.

Configuration
REQ-021 Macro CLKDIV_SYNC_EN defined: adds input sync_i (1 bit); a high sample SHALL reload Nl from div_i and set cnt to 0 in every enabled channel, so all ticks align on the next edge; sync_i takes priority over a simultaneous wrap or enable rising.
REQ-022 CLKDIV_SYNC_EN undefined: sync_i port and logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-023 Package clk_div_pkg SHALL hold channel-state encoding (IDLE, RUN) and the default NUM_CH/CNT_W constants.
REQ-024 Sub-module clk_div_ch SHALL implement one channel (counter, Nl latch, output registers); clk_div_gen instantiates NUM_CH copies in a generate loop and slices div_i.

Verification
REQ-025 Legacy ratio: ch0 en=1, div=4 -> tick_o[0] every 4 cycles, clk_o[0] 2 high/2 low (12.5 MHz at 50 MHz).
REQ-026 Odd divisor: div=5 -> clk_o 3 high/2 low, tick period 5; div=1 -> clk_o/tick_o constantly high.
REQ-027 Mid-period change: div=8, change to 3 at cnt=2 -> current period completes at 8, following periods are 3.
REQ-028 Disable/zero: en drop at cnt=5 -> outputs low next edge; div=0 with en=1 -> active_o=0, outputs stay low.
REQ-029 Reset mid-run: rst_n low asynchronously during clk_o high -> all outputs 0 without clock edge; release with en=1, div=6 -> first tick one edge later.
REQ-030 CLKDIV_SYNC_EN: ch0 div=4, ch1 div=6 free-running out of phase; sync_i pulse -> both tick on the next edge, ch0/ch1 ticks coincide every 12 cycles thereafter.
